control_unit: RTL

Hardwired Moore control sequencer that drives the `datapath` control inputs, replacing stimulus-driven control. It fetches an instruction via PC→MAR→memory→MDR→IR, decodes `IR[31:27]`, and steps through per-class execution states T3..T6. It emits the same strobes the datapath already accepts: bus-out selects, register load enables, GRA/GRB/GRC, Rin/Rout and the ALU `operation` code. It also reports run/halt status.

---
 rtl/control_unit_if.sv | 27 ++
 rtl/control_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control sequencer bundle: instruction/stop in, datapath strobes out
interface control_unit_if;
    logic [31:0] IR;
    logic        Stop;
    logic        PCout, Zlowout, ZHighout, MDRout;
    logic        MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin;
    logic        IncPC, Read;
    logic        GRA, GRB, GRC, Rin, Rout, BAout;
    logic [4:0]  operation;
    logic        Run;

    modport slave (
        input  IR, Stop,
        output PCout, Zlowout, ZHighout, MDRout,
        output MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin,
        output IncPC, Read, GRA, GRB, GRC, Rin, Rout, BAout,
        output operation, Run
    );

    modport master (
        output IR, Stop,
        input  PCout, Zlowout, ZHighout, MDRout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin,
        input  IncPC, Read, GRA, GRB, GRC, Rin, Rout, BAout,
        input  operation, Run
    );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - hardwired Moore sequencer: fetch T0..T2, per-class execute T3..T6, halt
module control_unit (
    input  logic          Clock,
    input  logic          Reset,
    control_unit_if.slave bus
);
    typedef enum logic [3:0] {
        S_RST  = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4   = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8
    } state_t;

    localparam logic [2:0] CL_ALU = 3'd0, CL_MD = 3'd1, CL_UN = 3'd2, CL_NOP = 3'd3, CL_HLT = 3'd4;

    function automatic logic [2:0] class_of(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: class_of = CL_ALU;
            5'b10000, 5'b01111:                     class_of = CL_MD;
            5'b10001, 5'b10010:                     class_of = CL_UN;
            5'b11011:                               class_of = CL_HLT;
            default:                                class_of = CL_NOP;
        endcase
    endfunction

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_class;
    logic       r_stop;
    logic [4:0] w_op;
    logic [2:0] w_live_class;
    logic [2:0] w_fetch_class;
    state_t     w_done;
    logic       w_unused_ir;

    assign w_op          = bus.IR[31:27];
    assign w_live_class  = class_of(w_op);
    assign w_fetch_class = w_live_class;
    assign w_unused_ir   = ^bus.IR[26:0];
    assign w_done        = r_stop ? S_HALT : S_T0;

    // Class and stop request are frozen at the T2 edge so later IR changes cannot divert the path.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_RST;
            r_class <= CL_NOP;
            r_stop  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_T2) begin
                r_class <= w_fetch_class;
                r_stop  <= bus.Stop;
            end else if (r_state == S_T0) begin
                r_stop  <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST: w_next = S_T0;
            S_T0:  w_next = S_T1;
            S_T1:  w_next = S_T2;
            S_T2: begin
                if (w_fetch_class == CL_HLT)      w_next = S_HALT;
                else if (w_fetch_class == CL_NOP) w_next = bus.Stop ? S_HALT : S_T0;
                else                              w_next = S_T3;
            end
            S_T3:  w_next = S_T4;
            S_T4:  w_next = (r_class == CL_UN) ? w_done : S_T5;
            S_T5:  w_next = (r_class == CL_MD) ? S_T6 : w_done;
            S_T6:  w_next = w_done;
            S_HALT: w_next = S_HALT;
            default: w_next = S_RST;
        endcase
    end

    // Execute-phase strobes decode the live opcode; the datapath IR holds it steady.
    always_comb begin
        bus.PCout = 1'b0; bus.Zlowout = 1'b0; bus.ZHighout = 1'b0; bus.MDRout = 1'b0;
        bus.MARin = 1'b0; bus.PCin = 1'b0; bus.MDRin = 1'b0; bus.IRin = 1'b0;
        bus.Yin = 1'b0; bus.Zin = 1'b0; bus.LOin = 1'b0; bus.HIin = 1'b0;
        bus.IncPC = 1'b0; bus.Read = 1'b0;
        bus.GRA = 1'b0; bus.GRB = 1'b0; bus.GRC = 1'b0;
        bus.Rin = 1'b0; bus.Rout = 1'b0; bus.BAout = 1'b0;
        bus.operation = 5'b00000;
        bus.Run = 1'b0;
        case (r_state)
            S_T0: begin
                bus.Run = 1'b1; bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
            end
            S_T1: begin
                bus.Run = 1'b1; bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
            end
            S_T2: begin
                bus.Run = 1'b1; bus.MDRout = 1'b1; bus.IRin = 1'b1;
            end
            S_T3: begin
                bus.Run = 1'b1;
                case (w_live_class)
                    CL_ALU: begin bus.GRB = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                    CL_MD:  begin bus.GRA = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                    CL_UN:  begin bus.GRB = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.operation = w_op; end
                    default: ;
                endcase
            end
            S_T4: begin
                bus.Run = 1'b1;
                case (w_live_class)
                    CL_ALU: begin bus.GRC = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.operation = w_op; end
                    CL_MD:  begin bus.GRB = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.operation = w_op; end
                    CL_UN:  begin bus.Zlowout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                bus.Run = 1'b1;
                case (w_live_class)
                    CL_ALU: begin bus.Zlowout = 1'b1; bus.GRA = 1'b1; bus.Rin = 1'b1; end
                    CL_MD:  begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                bus.Run = 1'b1;
                if (w_live_class == CL_MD) begin
                    bus.ZHighout = 1'b1; bus.HIin = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule
